// File: rtl/ntt_loop_ctrl.sv
// Stage/group/butterfly loop sequencer driving the NTT index unit and butterfly handshake.
// Optional stall counter enabled by defining NTT_LOOP_CTRL_STALL_CNT_EN.
module ntt_loop_ctrl #(
    parameter int LOG_N   = 8,
    parameter int STALL_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               mode_i,
    input  logic               abort_i,
    output logic               bf_valid_o,
    input  logic               bf_ready_i,
    output logic               set_idx_o,
    output logic               inc_idx_o,
    output logic               inc_j_o,
    output logic               sl_m_o,
    output logic               sl_j2_o,
    output logic [LOG_N-1:0]   stage_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [STALL_W-1:0] stall_cnt_o,
    output logic [2:0]         dbg_state_o
);

    // Handshake: a butterfly transfers in any cycle where bf_valid_o && bf_ready_i;
    // bf_valid_o stays high and the request is unchanged until that cycle (abort_i excepted).

    localparam int CW = LOG_N - 1;
    localparam logic [CW-1:0]    ALL1     = {CW{1'b1}};
    localparam logic [LOG_N-1:0] LAST_STG = LOG_N'(LOG_N - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SET     = 3'd1,
        S_RUN     = 3'd2,
        S_GRP_END = 3'd3,
        S_STG_END = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic             r_mode;
    logic [LOG_N-1:0] r_stage;
    logic [CW-1:0]    r_grp;
    logic [CW-1:0]    r_bf;

    logic [CW-1:0] w_len_m1;
    logic [CW-1:0] w_grp_m1;
    logic          w_last_bf;
    logic          w_last_grp;
    logic          w_last_stage;

    // len-1 and groups-1 built directly as CW-bit masks, so len = N/2 never overflows.
    assign w_len_m1     = r_mode ? ~(ALL1 << r_stage) : (ALL1 >> r_stage);
    assign w_grp_m1     = r_mode ? (ALL1 >> r_stage) : ~(ALL1 << r_stage);
    assign w_last_bf    = (r_bf == w_len_m1);
    assign w_last_grp   = (r_grp == w_grp_m1);
    assign w_last_stage = (r_stage == LAST_STG);

    assign stage_o     = r_stage;
    assign busy_o      = (r_state != S_IDLE);
    assign dbg_state_o = r_state;

    always_comb begin
        w_state_n  = r_state;
        bf_valid_o = 1'b0;
        set_idx_o  = 1'b0;
        inc_idx_o  = 1'b0;
        inc_j_o    = 1'b0;
        sl_m_o     = 1'b0;
        sl_j2_o    = 1'b0;
        done_o     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_state_n = S_SET;
            end
            S_SET: begin
                set_idx_o = 1'b1;
                w_state_n = S_RUN;
            end
            S_RUN: begin
                bf_valid_o = 1'b1;
                if (bf_ready_i) begin
                    if (w_last_bf) w_state_n = S_GRP_END;
                    else           inc_idx_o = 1'b1;
                end
            end
            S_GRP_END: begin
                inc_j_o   = 1'b1;
                w_state_n = w_last_grp ? S_STG_END : S_SET;
            end
            S_STG_END: begin
                sl_m_o    = 1'b1;
                sl_j2_o   = 1'b1;
                w_state_n = w_last_stage ? S_DONE : S_SET;
            end
            S_DONE: begin
                done_o    = 1'b1;
                w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
        if (abort_i) w_state_n = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_stage <= '0;
            r_grp   <= '0;
            r_bf    <= '0;
        end else begin
            r_state <= w_state_n;
            if (abort_i) begin
                r_stage <= '0;
                r_grp   <= '0;
                r_bf    <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_i) begin
                            r_mode  <= mode_i;
                            r_stage <= '0;
                            r_grp   <= '0;
                            r_bf    <= '0;
                        end
                    end
                    S_RUN: begin
                        if (bf_ready_i && !w_last_bf) r_bf <= r_bf + 1'b1;
                    end
                    S_GRP_END: begin
                        r_bf  <= '0;
                        r_grp <= w_last_grp ? '0 : r_grp + 1'b1;
                    end
                    S_STG_END: begin
                        if (!w_last_stage) r_stage <= r_stage + 1'b1;
                    end
                    S_DONE:  r_stage <= '0;
                    default: ;
                endcase
            end
        end
    end

`ifdef NTT_LOOP_CTRL_STALL_CNT_EN
    logic [STALL_W-1:0] r_stall;

    // Saturating; survives DONE and abort, restarts only on an accepted start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall <= '0;
        end else if (r_state == S_IDLE && start_i && !abort_i) begin
            r_stall <= '0;
        end else if (bf_valid_o && !bf_ready_i && r_stall != {STALL_W{1'b1}}) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ntt_loop_ctrl.sv
// Bench for ntt_loop_ctrl: LOG_N=3 and LOG_N=8 instances, group lengths scored from an expected queue.
module tb_ntt_loop_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start3, start8, mode, abort, ready, sel8;

  logic       d3_valid, d3_set, d3_inc, d3_incj, d3_slm, d3_slj2, d3_busy, d3_done;
  logic [2:0] d3_stage, d3_st;
  logic [15:0] d3_stall;
  logic       d8_valid, d8_set, d8_inc, d8_incj, d8_slm, d8_slj2, d8_busy, d8_done;
  logic [7:0] d8_stage;
  logic [2:0] d8_st;
  logic [15:0] d8_stall;

  ntt_loop_ctrl #(.LOG_N(3), .STALL_W(16)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start3), .mode_i(mode), .abort_i(abort),
    .bf_valid_o(d3_valid), .bf_ready_i(ready), .set_idx_o(d3_set), .inc_idx_o(d3_inc),
    .inc_j_o(d3_incj), .sl_m_o(d3_slm), .sl_j2_o(d3_slj2), .stage_o(d3_stage),
    .busy_o(d3_busy), .done_o(d3_done), .stall_cnt_o(d3_stall), .dbg_state_o(d3_st)
  );

  ntt_loop_ctrl #(.LOG_N(8), .STALL_W(16)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .mode_i(mode), .abort_i(abort),
    .bf_valid_o(d8_valid), .bf_ready_i(ready), .set_idx_o(d8_set), .inc_idx_o(d8_inc),
    .inc_j_o(d8_incj), .sl_m_o(d8_slm), .sl_j2_o(d8_slj2), .stage_o(d8_stage),
    .busy_o(d8_busy), .done_o(d8_done), .stall_cnt_o(d8_stall), .dbg_state_o(d8_st)
  );

  logic m_valid, m_set, m_inc, m_incj, m_slm, m_slj2, m_busy, m_done;
  logic [7:0] m_stage;
  logic [15:0] m_stall;
  assign m_valid = sel8 ? d8_valid : d3_valid;
  assign m_set   = sel8 ? d8_set   : d3_set;
  assign m_inc   = sel8 ? d8_inc   : d3_inc;
  assign m_incj  = sel8 ? d8_incj  : d3_incj;
  assign m_slm   = sel8 ? d8_slm   : d3_slm;
  assign m_slj2  = sel8 ? d8_slj2  : d3_slj2;
  assign m_busy  = sel8 ? d8_busy  : d3_busy;
  assign m_done  = sel8 ? d8_done  : d3_done;
  assign m_stage = sel8 ? d8_stage : {5'd0, d3_stage};
  assign m_stall = sel8 ? d8_stall : d3_stall;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] stg_q[$];
  int n_set, n_inc, n_incj, n_slm, n_slj2, n_acc, n_req, n_bad_stall, n_excl, n_done_after, done_cyc;

  task automatic push_model(input int lg, input bit md, output int total);
    int g, l;
    total = 0;
    for (int s = 0; s < lg; s++) begin
      g = md ? ((1 << (lg - 1)) >> s) : (1 << s);
      l = md ? (1 << s) : ((1 << (lg - 1)) >> s);
      for (int k = 0; k < g; k++) exp_q.push_back(16'(l));
      stg_q.push_back(16'(s));
      total += g * (l + 2) + 1;
    end
  endtask

  task automatic run_pass(input bit big, input bit md, input bit stall, input bit do_abort,
                          input bit extra_start);
    int total, grp_len, stall_left;
    bit req_stalled, aborted;
    logic [15:0] e;
    exp_q.delete();
    stg_q.delete();
    push_model(big ? 8 : 3, md, total);
    n_set = 0; n_inc = 0; n_incj = 0; n_slm = 0; n_slj2 = 0; n_acc = 0; n_req = 0;
    n_bad_stall = 0; n_excl = 0; n_done_after = 0; done_cyc = -1;
    grp_len = 0; stall_left = 0; req_stalled = 0; aborted = 0;
    sel8 = big; mode = md; ready = 1'b1;
    @(negedge clk);
    if (big) start8 = 1'b1; else start3 = 1'b1;
    for (int cyc = 1; cyc <= 5000; cyc++) begin
      @(negedge clk);
      start3 = 1'b0; start8 = 1'b0; mode = ~md;
      if (abort) begin
        abort = 1'b0;
        #1;
        n_cmp++;
        if (m_busy !== 1'b0 || m_valid !== 1'b0 ||
            {m_set, m_inc, m_incj, m_slm, m_slj2, m_done} !== 6'b0) begin
          n_err++;
          $display("FAIL abort_next: busy=%b valid=%b pulses=%b, required all 0", m_busy, m_valid,
                   {m_set, m_inc, m_incj, m_slm, m_slj2, m_done});
        end
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (m_done) n_done_after++;
        end
        break;
      end
      if (extra_start && cyc == 10) start3 = 1'b1;
      ready = 1'b1;
      if (stall && m_valid && n_req[0] && !req_stalled) begin
        req_stalled = 1'b1;
        stall_left = 3;
      end
      if (stall_left > 0) begin
        ready = 1'b0;
        stall_left--;
      end
      if (do_abort && !aborted && m_valid && m_stage == 8'd1) begin
        abort = 1'b1;
        aborted = 1'b1;
      end
      #1;
      if (!ready && (!m_valid || (m_set | m_inc | m_incj | m_slm | m_slj2))) n_bad_stall++;
      if (32'(m_set) + 32'(m_inc) + 32'(m_incj) > 1) n_excl++;
      if (m_set) n_set++;
      if (m_inc) n_inc++;
      if (m_incj) n_incj++;
      if (m_slm) n_slm++;
      if (m_slj2) n_slj2++;
      if (m_valid && ready) begin
        n_acc++; n_req++; grp_len++; req_stalled = 1'b0;
      end
      if (m_incj) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL group_len: got group of %0d, required no more groups", grp_len);
        end else begin
          e = exp_q.pop_front();
          if (grp_len !== int'(e)) begin
            n_err++;
            $display("FAIL group_len: got %0d, required %0d", grp_len, e);
          end
        end
        grp_len = 0;
      end
      if (m_slm) begin
        n_cmp++;
        e = (stg_q.size() == 0) ? 16'hffff : stg_q.pop_front();
        if ({8'd0, m_stage} !== e) begin
          n_err++;
          $display("FAIL stage_at_end: got %0d, required %0d", m_stage, e);
        end
      end
      if (m_done) begin
        done_cyc = cyc;
        break;
      end
    end
    if (!do_abort) begin
      n_cmp++;
      if (done_cyc < 0) begin
        n_err++;
        $display("FAIL done_timeout: no done_o within 5000 cycles, required %0d", total + 1);
      end
    end
    @(negedge clk);
    abort = 1'b0; ready = 1'b1; mode = 1'b0;
  endtask

  task automatic check_totals(input string nm, input int exp_done, input int e_set,
                              input int e_inc, input int e_sl, input int e_acc);
    n_cmp++;
    if (done_cyc !== exp_done || n_set !== e_set || n_incj !== e_set || n_inc !== e_inc ||
        n_slm !== e_sl || n_slj2 !== e_sl || n_acc !== e_acc || n_excl !== 0 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL %s: done=%0d set=%0d inc_j=%0d inc_idx=%0d sl_m=%0d sl_j2=%0d acc=%0d excl=%0d left=%0d, required %0d/%0d/%0d/%0d/%0d/%0d/%0d/0/0",
               nm, done_cyc, n_set, n_incj, n_inc, n_slm, n_slj2, n_acc, n_excl, exp_q.size(),
               exp_done, e_set, e_set, e_inc, e_sl, e_sl, e_acc);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start3 = 1'b0; start8 = 1'b0; mode = 1'b0; abort = 1'b0; ready = 1'b1; sel8 = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({d3_valid, d3_set, d3_inc, d3_incj, d3_slm, d3_slj2, d3_busy, d3_done} !== 8'b0 ||
        d3_stage !== 3'd0 || d3_stall !== 16'd0 || d3_st !== 3'd0) begin
      n_err++;
      $display("FAIL reset_dut3: outs=%b stage=%0d stall=%0d st=%0d, required all 0",
               {d3_valid, d3_set, d3_inc, d3_incj, d3_slm, d3_slj2, d3_busy, d3_done}, d3_stage, d3_stall, d3_st);
    end
    n_cmp++;
    if ({d8_valid, d8_set, d8_inc, d8_incj, d8_slm, d8_slj2, d8_busy, d8_done} !== 8'b0 ||
        d8_stage !== 8'd0 || d8_stall !== 16'd0 || d8_st !== 3'd0) begin
      n_err++;
      $display("FAIL reset_dut8: outs=%b stage=%0d stall=%0d, required all 0",
               {d8_valid, d8_set, d8_inc, d8_incj, d8_slm, d8_slj2, d8_busy, d8_done}, d8_stage, d8_stall);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ntt;
    run_pass(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_totals("ntt_totals", 30, 7, 5, 3, 12);
  endtask

  task automatic test_intt;
    run_pass(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_totals("intt_totals", 30, 7, 5, 3, 12);
  endtask

  task automatic test_stall;
    logic [15:0] exp_stall;
`ifdef NTT_LOOP_CTRL_STALL_CNT_EN
    exp_stall = 16'd18;
`else
    exp_stall = 16'd0;
`endif
    run_pass(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_totals("stall_totals", 48, 7, 5, 3, 12);
    n_cmp++;
    if (n_bad_stall !== 0) begin
      n_err++;
      $display("FAIL stall_hold: %0d stall cycles dropped valid or pulsed, required 0", n_bad_stall);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (d3_stall !== exp_stall) begin
      n_err++;
      $display("FAIL stall_cnt: got %0d, required %0d", d3_stall, exp_stall);
    end
  endtask

  task automatic test_abort;
    run_pass(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (n_done_after !== 0 || done_cyc !== -1) begin
      n_err++;
      $display("FAIL abort_done: done pulses=%0d done_cyc=%0d, required 0 and -1", n_done_after, done_cyc);
    end
    run_pass(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_totals("after_abort", 30, 7, 5, 3, 12);
  endtask

  task automatic test_abort_start;
    sel8 = 1'b0;
    @(negedge clk);
    start3 = 1'b1; abort = 1'b1;
    @(negedge clk);
    start3 = 1'b0; abort = 1'b0;
    #1;
    n_cmp++;
    if (d3_busy !== 1'b0 || d3_set !== 1'b0) begin
      n_err++;
      $display("FAIL abort_start: busy=%b set_idx=%b, required 0 0", d3_busy, d3_set);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (d3_busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_start_later: busy=%b, required 0", d3_busy);
    end
  endtask

  task automatic test_busy_start;
    run_pass(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_totals("busy_start", 30, 7, 5, 3, 12);
  endtask

  task automatic test_reset_mid;
    sel8 = 1'b0;
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    repeat ($urandom_range(4, 15)) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (d3_busy !== 1'b0 || d3_valid !== 1'b0 || d3_stage !== 3'd0 || d3_st !== 3'd0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b valid=%b stage=%0d st=%0d, required 0", d3_busy, d3_valid, d3_stage, d3_st);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (d3_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_idle: busy=%b, required 0", d3_busy);
    end
  endtask

  task automatic test_big;
    run_pass(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_totals("big_ntt", 1543, 255, 1024 - 255, 8, 1024);
  endtask

  initial begin
    test_reset();
    test_ntt();
    test_intt();
    test_stall();
    test_abort();
    test_abort_start();
    test_busy_start();
    test_reset_mid();
    test_big();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
